// File: rtl/trigger_conditioner.sv
// rtl/trigger_conditioner.sv - synchronize, filter and edge-count a target pin into a held glitch trigger
module trigger_conditioner #(
  parameter int FILTER_CYCLES  = 4,
  parameter int SKIP_WIDTH     = 8,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trig_in,
  input  logic                   arm,
  input  logic                   one_shot,
  input  logic                   edge_sel,
  input  logic [SKIP_WIDTH-1:0]  skip_count,
  input  logic                   done_in,
  output logic                   trig_out,
  output logic                   armed,
  output logic [COUNT_WIDTH-1:0] fire_count,
  output logic                   overrun
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, FIRE, HOLDOFF} state_t;

  state_t                state, state_next;
  logic                  sync1, sync2;
  logic [3:0]            match_cnt;
  logic                  filt, filt_d;
  logic                  arm_d;
  logic                  qual;
  logic [SKIP_WIDTH-1:0] skip_rem, skip_next;
  logic [HW-1:0]         hold_cnt, hold_next;
  logic                  spent, spent_next;
  logic                  fire_done;

  // Two-flop synchronizer followed by a run-length glitch filter on the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      filt      <= 1'b0;
      filt_d    <= 1'b0;
      match_cnt <= 4'd0;
    end else begin
      sync1  <= trig_in;
      sync2  <= sync1;
      filt_d <= filt;
      if (sync2 != filt) begin
        if (match_cnt == 4'(FILTER_CYCLES - 1)) begin
          filt      <= sync2;
          match_cnt <= 4'd0;
        end else begin
          match_cnt <= match_cnt + 4'd1;
        end
      end else begin
        match_cnt <= 4'd0;
      end
    end
  end

  // One-cycle pulse on a filtered transition in the selected direction.
  assign qual = (filt != filt_d) && (filt != edge_sel);

  // State, skip/holdoff counters and completed-fire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      skip_rem   <= '0;
      hold_cnt   <= '0;
      spent      <= 1'b0;
      fire_count <= '0;
    end else begin
      state    <= state_next;
      skip_rem <= skip_next;
      hold_cnt <= hold_next;
      spent    <= spent_next;
      if (fire_done) fire_count <= fire_count + 1'b1;
    end
  end

  // Next-state logic; spent blocks re-arming after a one-shot until arm is dropped.
  always_comb begin
    state_next = state;
    skip_next  = skip_rem;
    hold_next  = hold_cnt;
    spent_next = spent & arm;
    fire_done  = 1'b0;
    case (state)
      IDLE: begin
        if (arm && !spent) begin
          state_next = ARMED;
          skip_next  = skip_count;
        end
      end
      ARMED: begin
        if (!arm) begin
          state_next = IDLE;
        end else if (qual) begin
          if (skip_rem == '0) state_next = FIRE;
          else                skip_next  = skip_rem - 1'b1;
        end
      end
      FIRE: begin
        if (done_in) begin
          fire_done  = 1'b1;
          state_next = HOLDOFF;
          hold_next  = '0;
        end
      end
      HOLDOFF: begin
        if (!arm) begin
          state_next = IDLE;
        end else if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
          if (one_shot) begin
            state_next = IDLE;
            spent_next = 1'b1;
          end else begin
            state_next = ARMED;
            skip_next  = skip_count;
          end
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sticky overrun: an edge while busy sets it, a rising arm clears it; setting wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      arm_d   <= 1'b0;
    end else begin
      arm_d <= arm;
      if (qual && (state == FIRE || state == HOLDOFF)) overrun <= 1'b1;
      else if (arm && !arm_d)                          overrun <= 1'b0;
    end
  end

  assign trig_out = (state == FIRE);
  assign armed    = (state == ARMED);

endmodule

// File: tb/tb_trigger_conditioner.sv
// tb/tb_trigger_conditioner.sv - scoreboard bench for trigger_conditioner against a behavioural model
module tb_trigger_conditioner;

  localparam int F  = 4;
  localparam int SW = 8;
  localparam int HO = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig_in = 1'b0;
  logic          arm = 1'b0;
  logic          one_shot = 1'b0;
  logic          edge_sel = 1'b0;
  logic [SW-1:0] skip_count = '0;
  logic          done_in = 1'b0;
  logic          trig_out;
  logic          armed;
  logic [CW-1:0] fire_count;
  logic          overrun;

  int checks = 0;
  int passes = 0;

  trigger_conditioner #(
    .FILTER_CYCLES(F), .SKIP_WIDTH(SW), .HOLDOFF_CYCLES(HO), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .arm(arm), .one_shot(one_shot),
    .edge_sel(edge_sel), .skip_count(skip_count), .done_in(done_in),
    .trig_out(trig_out), .armed(armed), .fire_count(fire_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural reference: pin history, filtered level, and a mode/countdown view of the trigger flow.
  localparam int M_IDLE = 0, M_ARMED = 1, M_FIRE = 2, M_HOLD = 3;
  bit   pin_hist[$];
  bit   m_filt, m_filt_prev, m_arm_prev, m_ovr, m_spent;
  int   m_mode, m_skip, m_hold, m_fires;
  int   exp_q[$];

  task automatic model_step();
    bit edge_seen, all_diff;
    int mode_now;
    if (rst) begin
      pin_hist.delete();
      for (int i = 0; i < F + 2; i++) pin_hist.push_back(1'b0);
      m_filt = 0; m_filt_prev = 0; m_arm_prev = 0; m_ovr = 0; m_spent = 0;
      m_mode = M_IDLE; m_skip = 0; m_hold = 0; m_fires = 0;
    end else begin
      edge_seen = (m_filt != m_filt_prev) && (edge_sel ? !m_filt : m_filt);
      mode_now  = m_mode;
      if (edge_seen && (mode_now == M_FIRE || mode_now == M_HOLD)) m_ovr = 1;
      else if (arm && !m_arm_prev) m_ovr = 0;
      if (!arm) m_spent = 0;
      case (mode_now)
        M_IDLE:  if (arm && !m_spent) begin m_mode = M_ARMED; m_skip = skip_count; end
        M_ARMED: if (!arm) m_mode = M_IDLE;
                 else if (edge_seen) begin
                   if (m_skip == 0) m_mode = M_FIRE; else m_skip = m_skip - 1;
                 end
        M_FIRE:  if (done_in) begin
                   m_mode = M_HOLD; m_hold = HO; m_fires = (m_fires + 1) % (1 << CW);
                 end
        default: if (!arm) m_mode = M_IDLE;
                 else if (m_hold == 1) begin
                   if (one_shot) begin m_mode = M_IDLE; m_spent = 1; end
                   else begin m_mode = M_ARMED; m_skip = skip_count; end
                 end else m_hold = m_hold - 1;
      endcase
      // the synchronized value seen at this edge is the pin sampled two edges ago
      all_diff = 1;
      for (int i = 1; i <= F; i++)
        if (pin_hist[pin_hist.size() - 1 - i] == m_filt) all_diff = 0;
      m_filt_prev = m_filt;
      if (all_diff) m_filt = !m_filt;
      m_arm_prev = arm;
      pin_hist.push_back(trig_in);
      if (pin_hist.size() > F + 2) void'(pin_hist.pop_front());
    end
    exp_q.push_back({m_ovr, (m_mode == M_ARMED), (m_mode == M_FIRE), m_fires[CW-1:0]});
  endtask

  always @(posedge clk) model_step();

  // Monitor: compare every cycle's outputs with the oldest model prediction.
  always @(negedge clk) begin
    int exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {overrun, armed, trig_out, fire_count};
      checks++;
      if (act_v == exp_v) passes++;
      else $display("FAIL scoreboard: got ovr/arm/trig/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d at %0t",
                    act_v[CW+2], act_v[CW+1], act_v[CW], act_v[CW-1:0],
                    exp_v[CW+2], exp_v[CW+1], exp_v[CW], exp_v[CW-1:0], $time);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rearm();
    arm = 0; cyc(1); arm = 1; cyc(2);
  endtask

  task automatic done_pulse();
    done_in = 1; cyc(1); done_in = 0;
  endtask

  initial begin
    int n;
    cyc(3);
    chk("reset_trig", trig_out, 0);
    chk("reset_cnt", fire_count, 0);
    rst = 0; arm = 1; cyc(3);

    // pin-to-trigger latency and done handshake
    trig_in = 1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (trig_out) begin n = i; break; end
    end
    chk("latency", n, 7);
    cyc(3); done_pulse(); cyc(1);
    chk("done_drop", trig_out, 0);
    chk("fire_count1", fire_count, 1);
    cyc(20); trig_in = 0; cyc(10);

    // short glitch rejected
    trig_in = 1; cyc(3); trig_in = 0; cyc(10);
    chk("glitch_armed", armed, 1);
    chk("glitch_trig", trig_out, 0);

    // skip two rising edges
    skip_count = 2; rearm();
    repeat (3) begin trig_in = 1; cyc(8); trig_in = 0; cyc(8); end
    done_pulse(); cyc(20);
    // skip two falling edges
    edge_sel = 1; trig_in = 1; cyc(8); rearm();
    repeat (3) begin trig_in = 0; cyc(8); trig_in = 1; cyc(8); end
    chk("fall_fire", trig_out, 1);
    done_pulse(); cyc(20);

    // edge during holdoff sets overrun, arm rising clears it
    edge_sel = 0; skip_count = 0; trig_in = 0; cyc(8); rearm();
    trig_in = 1; cyc(8); trig_in = 0; cyc(8);
    done_pulse(); trig_in = 1; cyc(10);
    chk("overrun_set", overrun, 1);
    chk("overrun_nofire", trig_out, 0);
    cyc(20);
    chk("rearmed", armed, 1);
    rearm();
    chk("overrun_clr", overrun, 0);

    // one-shot parks in IDLE until arm toggles
    one_shot = 1; trig_in = 0; cyc(8);
    trig_in = 1; cyc(8); done_pulse(); cyc(25);
    chk("oneshot_idle", armed, 0);
    trig_in = 0; cyc(8); trig_in = 1; cyc(8);
    chk("oneshot_ignore", trig_out, 0);
    one_shot = 0; rearm();

    // reset in the middle of a fire
    trig_in = 0; cyc(8); trig_in = 1; cyc(8);
    chk("pre_rst_fire", trig_out, 1);
    rst = 1; trig_in = 0; cyc(1);
    chk("rst_trig", trig_out, 0);
    chk("rst_armed", armed, 0);
    rst = 0; cyc(2);

    // arm drop does not abort a fire
    trig_in = 1; cyc(8); arm = 0; cyc(5);
    chk("arm0_hold", trig_out, 1);
    done_pulse(); cyc(1);
    chk("arm0_release", trig_out, 0);
    arm = 1; cyc(3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) trig_in = ~trig_in;
      done_in = ($urandom_range(9) == 0);
      arm = ($urandom_range(59) != 0);
      if ($urandom_range(99) == 0) one_shot = ~one_shot;
      if ($urandom_range(39) == 0) edge_sel = ~edge_sel;
      if ($urandom_range(19) == 0) skip_count = SW'($urandom_range(3));
      rst = ($urandom_range(699) == 0);
      cyc(1);
    end
    rst = 0; done_in = 0; cyc(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/trigger_conditioner.md
Name: trigger_conditioner

Overview:
Front-end stage that drives the glitch generator's trigger input from an external target signal. It synchronizes and glitch-filters the raw pin, selects an edge, skips a programmable number of qualifying edges, and then asserts a level trigger. That trigger is held until the generator reports completion. A holdoff period follows before the block re-arms. It runs on the same PLL-derived fabric clock as the generator.

Parameters:
FILTER_CYCLES, 4, consecutive synchronized samples that must agree before the filtered level changes (1..15)
SKIP_WIDTH, 8, width of skip_count
HOLDOFF_CYCLES, 1024, clocks spent in HOLDOFF after a fire completes (>=1)
COUNT_WIDTH, 16, width of fire_count

Ports:
clk  input  1  fabric clock (PLL output)
rst  input  1  synchronous reset, active-high
trig_in  input  1  raw asynchronous target trigger pin
arm  input  1  level; 1 = enable arming; 0 = return to IDLE at next clock, except while in FIRE
one_shot  input  1  1 = go to IDLE after HOLDOFF instead of re-arming
edge_sel  input  1  0 = rising edge of filtered signal, 1 = falling edge
skip_count  input  SKIP_WIDTH  qualifying edges to ignore before firing; sampled on entry to ARMED
done_in  input  1  completion flag from glitch generator (done indicator)
trig_out  output  1  level trigger to glitch generator
armed  output  1  high in ARMED state
fire_count  output  COUNT_WIDTH  number of completed fires since reset; wraps
overrun  output  1  sticky; set when a qualifying edge occurs during FIRE or HOLDOFF; cleared by rst or a rising edge of arm

Behaviour:
- Reset values: trig_out=0, armed=0, fire_count=0, overrun=0, state=IDLE.
- The filter history and the filtered level reset to 0.
- Synchronizer: two flops on trig_in; no logic between them.
- Filter: counter of agreeing samples. The filtered level takes the synchronized value once it has differed from the current filtered level for FILTER_CYCLES consecutive clocks. Any mismatch restarts the count.
- Input-to-filtered latency: 2 + FILTER_CYCLES clocks.
- Qualifying edge: one-cycle pulse when the filtered level transitions in the direction selected by edge_sel. edge_sel is sampled combinationally every cycle.
- States:
  - IDLE: trig_out=0. When arm=1, load skip_remaining=skip_count and go to ARMED.
  - ARMED: armed=1. On a qualifying edge:
    - if skip_remaining==0, go to FIRE;
    - otherwise decrement skip_remaining.
    - If arm=0, go to IDLE; arm=0 takes priority over an edge in the same cycle.
  - FIRE: trig_out=1, registered, asserted the clock after the edge is detected. Total pin-to-trig_out latency is 3 + FILTER_CYCLES clocks. Stay in FIRE until done_in=1; then clear trig_out, increment fire_count, and go to HOLDOFF. arm=0 does not abort FIRE. The generator requires trigger to stay high until done.
  - HOLDOFF: trig_out=0. Count HOLDOFF_CYCLES clocks. Then:
    - arm=0 or one_shot=1: go to IDLE;
    - otherwise go to ARMED and reload skip_remaining.
- done_in asserted outside FIRE is ignored.
- Simultaneous events:
  - Qualifying edge in the same cycle done_in ends FIRE: counted as overrun; does not fire.
  - skip_count change while ARMED: no effect until the next reload.
- fire_count wraps from all-ones to 0 with no flag.
- rst mid-FIRE: trig_out drops on the next clock. fire_count is not incremented.
- overrun does not change state flow; it is a diagnostic only.

Test Plan:
- FILTER_CYCLES=4, trig_in 0→1 held → trig_out rises exactly 7 clocks after the first sampling edge; done_in pulse → trig_out falls next clock; fire_count=1.
- 3-clock high pulse on trig_in with FILTER_CYCLES=4 → filtered level unchanged; trig_out stays 0; armed stays 1.
- skip_count=2, edge_sel=0, three clean rising edges → only the third edge asserts trig_out; a falling-edge run with edge_sel=1 behaves the same.
- HOLDOFF_CYCLES=16, second edge arriving 5 clocks after done_in → no fire; overrun=1; re-armed after 16 clocks; overrun clears on a rising edge of arm.
- one_shot=1 → after one fire and holdoff, state is IDLE with armed=0; further edges are ignored until arm toggles.
- rst asserted while trig_out=1 → all outputs 0 the next clock; arm=0 during FIRE → trig_out is held until done_in.
